// File: rtl/puf_pkg.sv
// Shared definitions for the voting PUF mapping controller.
// State encoding, default widths and the vote-counter width helper.
package puf_pkg;

    localparam int DEF_IN_WIDTH  = 128;
    localparam int DEF_OUT_WIDTH = 16;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ARM     = 3'd1;
    localparam logic [2:0] ST_EVAL    = 3'd2;
    localparam logic [2:0] ST_RECOVER = 3'd3;
    localparam logic [2:0] ST_VOTE    = 3'd4;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        ARM     = ST_ARM,
        EVAL    = ST_EVAL,
        RECOVER = ST_RECOVER,
        VOTE    = ST_VOTE
    } state_t;

    // Ceiling log2, minimum 1 so a counter always has a bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/puf_vote_accum.sv
// Per-bit vote counters for the PUF response.
// Counts ones across evaluations and derives majority and disagreement.
module puf_vote_accum
    import puf_pkg::*;
#(
    parameter int OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int NUM_EVALS = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 sample,
    input  logic [OUT_WIDTH-1:0] bits,
    output logic [OUT_WIDTH-1:0] voted,
    output logic [OUT_WIDTH-1:0] unstable
);

    localparam int CW = clog2(NUM_EVALS + 1);
    localparam logic [CW-1:0] HALF = CW'(NUM_EVALS / 2);
    localparam logic [CW-1:0] ALL  = CW'(NUM_EVALS);

    logic [CW-1:0] cnt [OUT_WIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < OUT_WIDTH; i++) cnt[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < OUT_WIDTH; i++) cnt[i] <= '0;
        end else if (sample) begin
            for (int i = 0; i < OUT_WIDTH; i++)
                cnt[i] <= cnt[i] + CW'(bits[i]);
        end
    end

    always_comb begin
        voted    = '0;
        unstable = '0;
        for (int i = 0; i < OUT_WIDTH; i++) begin
            voted[i]    = cnt[i] > HALF;
            unstable[i] = (cnt[i] != '0) && (cnt[i] != ALL);
        end
    end

endmodule

// File: rtl/puf_vote_mapping.sv
// Challenge-to-response controller that evaluates the PUF several times
// and majority-votes the result, flagging bits that disagreed.
module puf_vote_mapping
    import puf_pkg::*;
#(
    parameter int IN_WIDTH      = DEF_IN_WIDTH,
    parameter int OUT_WIDTH     = DEF_OUT_WIDTH,
    parameter int SETTLE_CYCLES = 16,
    parameter int RESET_CYCLES  = 2,
    parameter int NUM_EVALS     = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 trigger,
    input  logic [IN_WIDTH-1:0]  dataIn,
    output logic                 done,
    output logic [OUT_WIDTH-1:0] dataOut,
    output logic [OUT_WIDTH-1:0] unstable,
    output logic                 busy,
    output logic [IN_WIDTH-1:0]  puf_challenge,
    output logic                 puf_trigger,
    output logic                 puf_reset,
    input  logic [OUT_WIDTH-1:0] puf_response
);

    if ((NUM_EVALS % 2) == 0 || NUM_EVALS < 1 || NUM_EVALS > 15) begin : g_bad_evals
        $error("NUM_EVALS must be odd and within 1..15");
    end
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("SETTLE_CYCLES must be within 1..255");
    end
    if (RESET_CYCLES < 1 || RESET_CYCLES > 255) begin : g_bad_recover
        $error("RESET_CYCLES must be within 1..255");
    end

    localparam logic [7:0] SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] RECOVER_LAST = 8'(RESET_CYCLES - 1);
    localparam logic [3:0] EVAL_LAST    = 4'(NUM_EVALS - 1);

    state_t               state;
    logic [7:0]           settle_cnt;
    logic [7:0]           rec_cnt;
    logic [3:0]           eval_cnt;
    logic                 acc_clear;
    logic                 acc_sample;
    logic [OUT_WIDTH-1:0] voted;
    logic [OUT_WIDTH-1:0] flaky;

    assign acc_clear  = (state == IDLE) && trigger;
    assign acc_sample = (state == EVAL) && (settle_cnt == SETTLE_LAST);
    assign busy       = (state != IDLE);

    puf_vote_accum #(
        .OUT_WIDTH (OUT_WIDTH),
        .NUM_EVALS (NUM_EVALS)
    ) u_accum (
        .clk      (clk),
        .reset    (reset),
        .clear    (acc_clear),
        .sample   (acc_sample),
        .bits     (puf_response),
        .voted    (voted),
        .unstable (flaky)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            done          <= 1'b0;
            dataOut       <= '0;
            unstable      <= '0;
            puf_challenge <= '0;
            puf_trigger   <= 1'b0;
            puf_reset     <= 1'b1;
            settle_cnt    <= '0;
            rec_cnt       <= '0;
            eval_cnt      <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (trigger) begin
                        puf_challenge <= dataIn;
                        eval_cnt      <= '0;
                        puf_reset     <= 1'b0;
                        state         <= ARM;
                    end
                end
                ARM: begin
                    puf_trigger <= 1'b1;
                    settle_cnt  <= '0;
                    state       <= EVAL;
                end
                EVAL: begin
                    settle_cnt <= settle_cnt + 8'd1;
                    if (acc_sample) begin
                        puf_trigger <= 1'b0;
                        puf_reset   <= 1'b1;
                        eval_cnt    <= eval_cnt + 4'd1;
                        rec_cnt     <= '0;
                        state       <= (eval_cnt == EVAL_LAST) ? VOTE : RECOVER;
                    end
                end
                RECOVER: begin
                    rec_cnt <= rec_cnt + 8'd1;
                    if (rec_cnt == RECOVER_LAST) begin
                        puf_reset <= 1'b0;
                        state     <= ARM;
                    end
                end
                VOTE: begin
                    dataOut  <= voted;
                    unstable <= flaky;
                    done     <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_vote_mapping.sv
// Directed bench for the voting PUF mapping controller.
// Two instances: default five-vote build and a single-evaluation build.
module tb_puf_vote_mapping;

    logic         clk = 1'b0;
    logic         reset;
    logic         trigger;
    logic [127:0] dataIn;
    logic         done;
    logic [15:0]  dataOut;
    logic [15:0]  unstable;
    logic         busy;
    logic [127:0] puf_challenge;
    logic         puf_trigger;
    logic         puf_reset;
    logic [15:0]  puf_response;

    logic         trigger1;
    logic         done1;
    logic [15:0]  dataOut1;
    logic [15:0]  unstable1;
    logic         busy1;
    logic [127:0] puf_challenge1;
    logic         puf_trigger1;
    logic         puf_reset1;

    int compared = 0;
    int mismatched = 0;

    logic [15:0] resp_tab [5];
    int          resp_idx;
    logic        prev_trig;

    int n_edges, n_pulses, n_trig, n_gap, n_done;
    logic poke;

    always #5 clk = ~clk;

    puf_vote_mapping dut (
        .clk           (clk),
        .reset         (reset),
        .trigger       (trigger),
        .dataIn        (dataIn),
        .done          (done),
        .dataOut       (dataOut),
        .unstable      (unstable),
        .busy          (busy),
        .puf_challenge (puf_challenge),
        .puf_trigger   (puf_trigger),
        .puf_reset     (puf_reset),
        .puf_response  (puf_response)
    );

    puf_vote_mapping #(.NUM_EVALS(1)) dut1 (
        .clk           (clk),
        .reset         (reset),
        .trigger       (trigger1),
        .dataIn        (128'h77),
        .done          (done1),
        .dataOut       (dataOut1),
        .unstable      (unstable1),
        .busy          (busy1),
        .puf_challenge (puf_challenge1),
        .puf_trigger   (puf_trigger1),
        .puf_reset     (puf_reset1),
        .puf_response  (16'h1234)
    );

    // PUF model: next table entry after each completed trigger pulse.
    assign puf_response = resp_tab[resp_idx];

    always @(negedge clk) begin
        if (prev_trig && !puf_trigger && resp_idx < 4) resp_idx <= resp_idx + 1;
        prev_trig <= puf_trigger;
    end

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_resp(input logic [15:0] a, b, c, d, e);
        resp_tab[0] = a; resp_tab[1] = b; resp_tab[2] = c;
        resp_tab[3] = d; resp_tab[4] = e;
        resp_idx = 0;
    endtask

    // Next posedge is the accepting edge; counts edges up to done.
    task automatic wait_done(input logic hold, input int limit);
        logic pt;
        n_edges = 0; n_pulses = 0; n_trig = 0; n_gap = 0; n_done = 0;
        pt = 1'b0;
        @(posedge clk);
        #1;
        if (!hold) trigger = 1'b0;
        while (n_edges < limit) begin
            @(posedge clk);
            #1;
            n_edges++;
            if (puf_trigger && !pt) n_pulses++;
            pt = puf_trigger;
            if (puf_trigger) n_trig++;
            if (busy && puf_reset) n_gap++;
            if (poke) begin
                trigger = $urandom_range(0, 1);
                dataIn  = {4{$urandom}};
            end
            if (done) begin
                n_done++;
                break;
            end
        end
        if (!done) check("done_timeout", 0, 1);
    endtask

    initial begin
        reset = 1'b1; trigger = 1'b0; trigger1 = 1'b0; dataIn = '0;
        poke = 1'b0; prev_trig = 1'b0;
        set_resp(16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        #1;
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_ptrig", puf_trigger, 0);
        check("rst_preset", puf_reset, 1);
        check("rst_chal", puf_challenge, 0);
        check("rst_dout", dataOut, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // stable PUF
        set_resp(16'hA5C3, 16'hA5C3, 16'hA5C3, 16'hA5C3, 16'hA5C3);
        dataIn = 128'h1; trigger = 1'b1;
        wait_done(1'b0, 200);
        check("stable_lat", n_edges, 94);
        check("stable_dout", dataOut, 16'hA5C3);
        check("stable_unst", unstable, 0);
        check("stable_pulses", n_pulses, 5);
        check("stable_trigcyc", n_trig, 80);
        // four 2-cycle gaps plus the VOTE cycle
        check("stable_gapcyc", n_gap, 9);
        check("stable_chal", puf_challenge, 128'h1);
        @(posedge clk); #1;
        check("done_pulse", done, 0);
        check("idle_preset", puf_reset, 1);

        // noisy PUF
        @(negedge clk);
        set_resp(16'h00FF, 16'h00FF, 16'h0F0F, 16'h00FF, 16'hF0FF);
        dataIn = 128'h2; trigger = 1'b1;
        wait_done(1'b0, 200);
        check("noisy_lat", n_edges, 94);
        check("noisy_dout", dataOut, 16'h00FF);
        check("noisy_unst", unstable, 16'hFFF0);

        // single evaluation build
        @(negedge clk);
        trigger1 = 1'b1;
        @(posedge clk); #1;
        trigger1 = 1'b0;
        n_edges = 0;
        while (n_edges < 100 && !done1) begin
            @(posedge clk); #1;
            n_edges++;
        end
        check("n1_lat", n_edges, 18);
        check("n1_dout", dataOut1, 16'h1234);
        check("n1_unst", unstable1, 0);

        // back-to-back with trigger held
        @(negedge clk);
        set_resp(16'h3C3C, 16'h3C3C, 16'h3C3C, 16'h3C3C, 16'h3C3C);
        dataIn = 128'h1; trigger = 1'b1;
        wait_done(1'b1, 200);
        check("b2b_lat1", n_edges, 94);
        dataIn = 128'hDEAD;
        resp_idx = 0;
        wait_done(1'b0, 200);
        check("b2b_lat2", n_edges, 94);
        check("b2b_chal", puf_challenge, 128'hDEAD);
        check("b2b_dout", dataOut, 16'h3C3C);

        // toggling inputs while busy
        @(negedge clk);
        set_resp(16'h5555, 16'h5555, 16'h5555, 16'h5555, 16'h5555);
        dataIn = 128'hBEEF; trigger = 1'b1;
        @(posedge clk); #1;
        trigger = 1'b0;
        poke = 1'b1;
        n_done = 0;
        for (int i = 0; i < 92; i++) begin
            @(posedge clk); #1;
            if (done) n_done++;
            if (i == 50) check("poke_chal", puf_challenge, 128'hBEEF);
            trigger = $urandom_range(0, 1);
            dataIn  = {4{$urandom}};
        end
        poke = 1'b0;
        trigger = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        check("poke_ndone", n_done, 1);
        check("poke_dout", dataOut, 16'h5555);

        // reset mid-operation
        @(negedge clk);
        dataIn = 128'hCAFE; trigger = 1'b1;
        @(posedge clk); #1;
        trigger = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("mid_busy", busy, 0);
        check("mid_done", done, 0);
        check("mid_dout", dataOut, 0);
        check("mid_ptrig", puf_trigger, 0);
        check("mid_preset", puf_reset, 1);
        check("mid_chal", puf_challenge, 0);
        @(negedge clk);
        reset = 1'b0;
        n_done = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        check("mid_nodone", n_done, 0);
        @(negedge clk);
        set_resp(16'h0F0F, 16'h0F0F, 16'h0F0F, 16'h0F0F, 16'h0F0F);
        dataIn = 128'h3; trigger = 1'b1;
        wait_done(1'b0, 200);
        check("post_lat", n_edges, 94);
        check("post_dout", dataOut, 16'h0F0F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
